// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit storage stage: hold, shift, rotate, load, clear and invert.
// Counts shift/rotate steps since the last load/clear (saturating at WIDTH) and
// emits a one-cycle registered pulse on the edge where the count first reaches WIDTH.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       d,
    input  logic                   sin_r,
    input  logic                   sin_l,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qb,
    output logic                   sout_r,
    output logic                   sout_l,
    output logic [$clog2(WIDTH):0] shift_cnt,
    output logic                   word_done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             step;

    // Next-state selection for data, step counter and word-done pulse.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        step   = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR: begin
                    q_d  = {sin_r, q_q[WIDTH-1:1]};
                    step = 1'b1;
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], sin_l};
                    step = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    step = 1'b1;
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    step = 1'b1;
                end
                MODE_CLR: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
                MODE_INV: q_d = ~q_q;
                default:  q_d = q_q;
            endcase
            // Direction does not matter: every shift or rotate is one step.
            // The pulse fires only on the WIDTH-1 -> WIDTH transition, so a
            // saturated counter never re-pulses until LOAD/CLR/reset rearms it.
            if (step && (cnt_q != CNT_FULL)) begin
                cnt_d  = cnt_q + 1'b1;
                done_d = (cnt_q == CNT_LAST);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q         = q_q;
    assign qb        = ~q_q;
    assign sout_r    = q_q[0];
    assign sout_l    = q_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign word_done = done_q;

endmodule
